// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 4-bit read cycles (BF/AC or RAM byte), optional busy-flag polling; owns bus handoff via data_oe.
// rd_valid 1+T_AS+2*(T_EH+T_EL) cycles after accept, +2*(T_EH+T_EL) per extra poll; rd_req taken only in IDLE, never queued.
module lcd_reader #(
  parameter int unsigned T_AS      = 2,
  parameter int unsigned T_EH      = 12,
  parameter int unsigned T_EL      = 12,
  parameter int unsigned MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       wait_busy,
  input  logic [3:0] lcd_d_in,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       timeout,
  output logic       RS,
  output logic       RW,
  output logic       E,
  output logic       data_oe
);

  localparam logic [7:0] AS_LAST = 8'(T_AS - 1);
  localparam logic [7:0] EH_LAST = 8'(T_EH - 1);
  localparam logic [7:0] EL_LAST = 8'(T_EL - 1);
  localparam logic [7:0] MAX_P   = 8'(MAX_POLLS);

  typedef enum logic [3:0] {
    RECOVER,
    IDLE,
    RELEASE,
    SETUP,
    EH1,
    EL1,
    EH2,
    EL2,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] poll_cnt;
  logic [7:0] poll_next;
  logic       rs_q;
  logic       poll_q;

  // Saturating so a misconfigured limit can never wrap into another poll.
  always_comb begin
    poll_next = (poll_cnt >= MAX_P) ? MAX_P : poll_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RECOVER;
      cnt       <= 8'd0;
      poll_cnt  <= 8'd0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      rd_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 8'd0;
      busy_flag <= 1'b0;
      addr_cnt  <= 7'd0;
      timeout   <= 1'b0;
      RS        <= 1'b0;
      RW        <= 1'b0;
      E         <= 1'b0;
      data_oe   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        RECOVER: begin
          state    <= IDLE;
          data_oe  <= 1'b1;
          rd_ready <= 1'b1;
        end
        IDLE: begin
          if (rd_req) begin
            rs_q     <= rd_rs;
            poll_q   <= wait_busy & ~rd_rs;
            poll_cnt <= 8'd0;
            RS       <= rd_rs;
            data_oe  <= 1'b0;
            rd_ready <= 1'b0;
            cnt      <= 8'd0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          // data_oe already dropped one cycle ago, so RW may rise now.
          RW    <= 1'b1;
          cnt   <= 8'd0;
          state <= SETUP;
        end
        SETUP: begin
          if (cnt == AS_LAST) begin
            cnt   <= 8'd0;
            E     <= 1'b1;
            state <= EH1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EH1: begin
          if (cnt == EH_LAST) begin
            rd_data[7:4] <= lcd_d_in;
            cnt          <= 8'd0;
            E            <= 1'b0;
            state        <= EL1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EL1: begin
          if (cnt == EL_LAST) begin
            cnt   <= 8'd0;
            E     <= 1'b1;
            state <= EH2;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EH2: begin
          if (cnt == EH_LAST) begin
            rd_data[3:0] <= lcd_d_in;
            cnt          <= 8'd0;
            E            <= 1'b0;
            state        <= EL2;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EL2: begin
          if (cnt == EL_LAST) begin
            cnt      <= 8'd0;
            poll_cnt <= poll_next;
            if (poll_q && rd_data[7] && (poll_next < MAX_P)) begin
              E     <= 1'b1;
              state <= EH1;
            end else begin
              RW       <= 1'b0;
              rd_valid <= 1'b1;
              timeout  <= poll_q & rd_data[7];
              if (!rs_q) begin
                busy_flag <= rd_data[7];
                addr_cnt  <= rd_data[6:0];
              end
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          // RW went low on entry to DONE; bus returns to the writer one cycle later.
          data_oe  <= 1'b1;
          rd_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          RW       <= 1'b0;
          E        <= 1'b0;
          data_oe  <= 1'b0;
          rd_ready <= 1'b0;
          state    <= RECOVER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: LCD read model answering E pulses, bus-ordering monitor, directed and random reads.
module tb_lcd_reader;

  localparam int unsigned T_AS      = 2;
  localparam int unsigned T_EH      = 12;
  localparam int unsigned T_EL      = 12;
  localparam int unsigned MAX_POLLS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_req;
  logic       rd_rs;
  logic       wait_busy;
  logic [3:0] lcd_d_in;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       timeout;
  logic       RS;
  logic       RW;
  logic       E;
  logic       data_oe;

  int checks   = 0;
  int failures = 0;
  int rv_count = 0;
  int e_rises  = 0;

  logic [7:0] lst [8];
  logic [7:0] resp_q [$];
  logic [7:0] cur_b;
  logic       half;
  logic       e_q;
  logic       exp_bf;
  logic [6:0] exp_ac;

  logic rw_p  = 1'b0;
  logic oe_p  = 1'b0;
  logic rs_p  = 1'b0;
  logic e_p   = 1'b0;

  always #12.5 clk = ~clk;

  lcd_reader #(
    .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_rs(rd_rs), .wait_busy(wait_busy),
    .lcd_d_in(lcd_d_in), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy_flag(busy_flag), .addr_cnt(addr_cnt), .timeout(timeout),
    .RS(RS), .RW(RW), .E(E), .data_oe(data_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LCD model: first E pulse of a read presents the high nibble of the next queued byte, second the low nibble.
  always @(posedge clk) begin
    if (rst) begin
      half     <= 1'b0;
      lcd_d_in <= 4'h0;
    end else if (E && !e_q && RW) begin
      if (!half) begin
        if (resp_q.size() > 0) cur_b = resp_q.pop_front();
        else cur_b = 8'h80;
        lcd_d_in <= cur_b[7:4];
        half     <= 1'b1;
      end else begin
        lcd_d_in <= cur_b[3:0];
        half     <= 1'b0;
      end
    end
    e_q <= E;
  end

  // Bus-ordering monitor, evaluated only on the edges of interest.
  always @(negedge clk) begin
    if (!rst) begin
      if (RW && !rw_p) chk("rw_rise_after_oe_low", {oe_p, data_oe}, 0);
      if (data_oe && !oe_p) chk("oe_rise_after_rw_low", {rw_p, RW}, 0);
      if (E && !e_p) chk("e_only_while_reading", {RW, data_oe}, 2'b10);
      if (RS !== rs_p) chk("rs_change_while_idle", {RW, E}, 0);
    end
    if (rd_valid) rv_count++;
    if (E && !e_p) e_rises++;
    rw_p = RW;
    oe_p = data_oe;
    rs_p = RS;
    e_p  = E;
  end

  task automatic do_read(input logic rs, input logic wb, input logic poke);
    int         n;
    int         k;
    int         exp_k;
    int         rv0;
    int         e0;
    int         w;
    logic       poll;
    logic [7:0] last;
    poll = wb && !rs;
    n    = 0;
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last = lst[i];
      n    = i + 1;
      if (!poll || !last[7] || n >= int'(MAX_POLLS)) break;
    end
    exp_k = 1 + int'(T_AS) + n * 2 * int'(T_EH + T_EL);
    resp_q.delete();
    for (int i = 0; i < 8; i++) resp_q.push_back(lst[i]);

    w = 0;
    while (!rd_ready && w < 20) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    chk("ready_before_req", rd_ready, 1);
    rv0       = rv_count;
    e0        = e_rises;
    rd_req    = 1'b1;
    rd_rs     = rs;
    wait_busy = wb;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    k = 0;
    while (!rd_valid && k < 2000) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      rd_req = poke && (k == 20);
    end
    chk("valid_latency", k, exp_k);
    chk("rd_data", rd_data, last);
    chk("timeout", timeout, poll && last[7]);
    if (!rs) begin
      exp_bf = last[7];
      exp_ac = last[6:0];
    end
    chk("busy_flag", busy_flag, exp_bf);
    chk("addr_cnt", addr_cnt, exp_ac);
    chk("rs_held", RS, rs);
    chk("done_bus", {RW, data_oe, rd_ready}, 0);
    chk("e_pulses", e_rises - e0, 2 * n);
    rd_req = poke;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    chk("idle_after_done", {rd_valid, rd_ready, data_oe, timeout}, 4'b0110);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("one_valid_pulse", rv_count - rv0, 1);
    chk("no_reissue", rd_ready, 1);
  endtask

  initial begin
    int         rv_saved;
    logic [7:0] low;
    rst       = 1'b1;
    rd_req    = 1'b0;
    rd_rs     = 1'b0;
    wait_busy = 1'b0;
    exp_bf    = 1'b0;
    exp_ac    = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {RS, RW, E, data_oe, rd_valid, timeout, rd_ready, rd_data, busy_flag, addr_cnt}, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_recover", {data_oe, rd_ready, RW}, 3'b110);

    lst = '{8'h4A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_read(1'b1, 1'b0, 1'b0);
    lst = '{8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_read(1'b0, 1'b0, 1'b0);
    lst = '{8'h80, 8'h80, 8'h80, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
    do_read(1'b0, 1'b1, 1'b0);
    lst = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    do_read(1'b0, 1'b1, 1'b0);
    lst = '{8'h9C, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    do_read(1'b1, 1'b1, 1'b0);
    lst = '{8'hC3, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_read(1'b0, 1'b0, 1'b1);

    // Reset in the middle of the second E pulse.
    rv_saved  = rv_count;
    resp_q.delete();
    resp_q.push_back(8'h3C);
    rd_req    = 1'b1;
    rd_rs     = 1'b1;
    wait_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_eh2_e_high", E, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_mid_read", {E, RW, data_oe, rd_valid, timeout, rd_ready}, 0);
    exp_bf = 1'b0;
    exp_ac = 7'd0;
    @(posedge clk);
    @(negedge clk);
    chk("oe_back_after_recover", {data_oe, rd_ready}, 2'b11);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("no_valid_after_reset", rv_count, rv_saved);
    lst = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_read(1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int nb;
      nb = $urandom_range(0, 5);
      for (int i = 0; i < 8; i++) begin
        low    = 8'($urandom);
        lst[i] = (i < nb) ? {1'b1, low[6:0]} : {1'b0, low[6:0]};
      end
      do_read(1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
